// File: rtl/fft_out_reorder.sv
// fft_out_reorder: 32-pt MDC FFT output reorder, ping-pong banks.
// Dual-lane bit-reversed beats in, natural-order X[0..31] out (valid/ready).
// Ports: clk, rst_n (async low); in_valid/in_ready, in_up_re/im, in_l_re/im;
//        out_valid/out_ready, out_re/im, out_index (bin k), out_last (k==31).
module fft_out_reorder #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_l_re,
  input  logic signed [WIDTH-1:0] in_l_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [4:0]              out_index,
  output logic                    out_last
);

  logic signed [WIDTH-1:0] r_re [2][32];
  logic signed [WIDTH-1:0] r_im [2][32];

  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [3:0] r_wr_cnt;
  logic [4:0] r_rd_cnt;

  logic       w_acc;
  logic       w_rd;
  logic       w_wr_last;
  logic       w_rd_last;
  logic [3:0] w_br;
  logic [1:0] w_set;
  logic [1:0] w_clr;

  always_comb begin
    w_br      = {r_wr_cnt[0], r_wr_cnt[1],
                 r_wr_cnt[2], r_wr_cnt[3]};
    in_ready  = !r_full[r_wr_bank];
    out_valid = r_full[r_rd_bank];
    w_acc     = in_valid && in_ready;
    w_rd      = out_valid && out_ready;
    w_wr_last = w_acc && (r_wr_cnt == 4'd15);
    w_rd_last = w_rd && (r_rd_cnt == 5'd31);
    w_set     = '0;
    w_clr     = '0;
    // Set and clear always target different banks.
    if (w_wr_last) w_set[r_wr_bank] = 1'b1;
    if (w_rd_last) w_clr[r_rd_bank] = 1'b1;
    out_re    = '0;
    out_im    = '0;
    if (out_valid) begin
      out_re = r_re[r_rd_bank][r_rd_cnt];
      out_im = r_im[r_rd_bank][r_rd_cnt];
    end
    out_index = r_rd_cnt;
    out_last  = out_valid && (r_rd_cnt == 5'd31);
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_re[r_wr_bank][{1'b0, w_br}] <= in_up_re;
      r_im[r_wr_bank][{1'b0, w_br}] <= in_up_im;
      r_re[r_wr_bank][{1'b1, w_br}] <= in_l_re;
      r_im[r_wr_bank][{1'b1, w_br}] <= in_l_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= 4'd0;
      r_rd_cnt  <= 5'd0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_acc) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
      end
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd) begin
        r_rd_cnt <= r_rd_cnt + 5'd1;
      end
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: frame-queue model + directed vectors.
// Checks fft_out_reorder every cycle plus literal spot values.
module tb_fft_out_reorder;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [8:0] in_up_re, in_up_im;
  logic signed [8:0] in_l_re, in_l_im;
  logic out_valid;
  logic out_ready;
  logic signed [8:0] out_re, out_im;
  logic [4:0] out_index;
  logic out_last;

  fft_out_reorder #(.WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_up_re(in_up_re), .in_up_im(in_up_im),
    .in_l_re(in_l_re), .in_l_im(in_l_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int brev(input int m);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++)
      if (((m >> i) & 1) != 0) r += 1 << (3 - i);
    return r;
  endfunction

  // Model: queue of complete frames in natural order,
  // plus the partial frame being assembled.
  typedef logic [31:0][17:0] frame_t;
  frame_t fq[$];
  frame_t part;
  int nb = 0;
  int k  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      nb = 0;
      k  = 0;
    end else begin
      bit acc, rd;
      acc = in_valid && (fq.size() < 2);
      rd  = (fq.size() > 0) && out_ready;
      if (rd) begin
        if (k == 31) begin
          void'(fq.pop_front());
          k = 0;
        end else k++;
      end
      if (acc) begin
        part[brev(nb)]      = {in_up_re, in_up_im};
        part[brev(nb) + 16] = {in_l_re, in_l_im};
        if (nb == 15) begin
          fq.push_back(part);
          nb = 0;
        end else nb++;
      end
    end
  end

  always @(negedge clk) begin
    frame_t t;
    logic signed [8:0] er, ei;
    bit ev;
    ev = fq.size() > 0;
    er = '0;
    ei = '0;
    if (ev) begin
      t  = fq[0];
      er = t[k][17:9];
      ei = t[k][8:0];
    end
    chk("in_ready", in_ready, fq.size() < 2);
    chk("out_valid", out_valid, ev);
    chk("out_re", out_re, er);
    chk("out_im", out_im, ei);
    chk("out_index", out_index, k);
    chk("out_last", out_last, ev && k == 31);
  end

  logic signed [8:0] f_re [32];
  logic signed [8:0] f_im [32];

  task automatic send(input int nbeats);
    int b, n;
    for (int m = 0; m < nbeats; m++) begin
      b = brev(m);
      in_valid = 1'b1;
      in_up_re = f_re[b];
      in_up_im = f_im[b];
      in_l_re  = f_re[b + 16];
      in_l_im  = f_im[b + 16];
      @(negedge clk);
      n = 0;
      while (fq.size() >= 2 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: beat %0d never accepted", m);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (fq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d frames left", fq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int a, input int b, input int c);
    for (int i = 0; i < 32; i++) begin
      f_re[i] = 9'(a * i + c);
      f_im[i] = 9'(b * i - c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_up_re = '0; in_up_im = '0;
    in_l_re = '0; in_l_im = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;

    // 1: ramp frame, literal stream
    out_ready = 1'b1;
    fill(1, -1, 0);
    send(16);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_re", out_re, i);
      chk("t1_im", out_im, -i);
      chk("t1_idx", out_index, i);
      chk("t1_last", out_last, i == 31);
    end
    @(negedge clk);
    chk("t1_done", out_valid, 0);
    @(posedge clk);
    #1;

    // 2: back-to-back frames
    for (int f = 0; f < 3; f++) begin
      fill(3 + f, 5, -50 + 7 * f);
      send(16);
    end
    drain();

    // 3: out_ready 1,0,0,1 pattern
    fork
      begin
        fill(-2, 7, 20);
        send(16);
        fill(4, -3, -60);
        send(16);
      end
      begin
        for (int i = 0; i < 160; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    // 4: stalled output, 3 frames offered
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          fill(1 + f, 2, 11 * f - 30);
          send(16);
        end
      end
      begin
        repeat (45) @(posedge clk);
        #1;
        chk("t4_in_ready", in_ready, 0);
        chk("t4_out_valid", out_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: reset mid-frame with a frame buffered
    out_ready = 1'b0;
    fill(5, 1, -90);
    send(16);
    fill(-1, -2, 77);
    send(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_re", out_re, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    fill(2, -5, 33);
    send(16);
    drain();

    // 6: extremes
    for (int i = 0; i < 32; i++) begin
      f_re[i] = -9'sd256;
      f_im[i] = 9'sd255;
    end
    send(16);
    @(negedge clk);
    chk("t6_re", out_re, -256);
    chk("t6_im", out_im, 255);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
